// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a-b (mod 2^WIDTH), one bit per clock LSB first, IDLE/RUN/DONE sequencing.
// Optional macro SERIAL_SUB_OVF_EN adds the registered signed-overflow output ovf_out.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy_out,
  output logic             done_out,
  output logic [WIDTH-1:0] diff_out,
`ifdef SERIAL_SUB_OVF_EN
  output logic             ovf_out,
`endif
  output logic             borrow_out
);

  localparam int            CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_d;
  logic [WIDTH-1:0] sub_q;
  logic [CW-1:0]    cnt_q;
  logic             bw_q;
  logic             bw_d;
  logic             bit_d;

  assign bit_d = acc_q[0] ^ sub_q[0] ^ bw_q;
  assign bw_d  = (~acc_q[0] & sub_q[0]) | (~(acc_q[0] ^ sub_q[0]) & bw_q);

  // acc_q holds the minuend and the result at once: minuend bits leave at the
  // LSB while difference bits enter at the MSB, so after WIDTH shifts bit i sits at i.
  if (WIDTH == 1) begin : g_w1
    assign acc_d = bit_d;
  end else begin : g_wn
    assign acc_d = {bit_d, acc_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= IDLE;
      acc_q      <= {WIDTH{1'b0}};
      sub_q      <= {WIDTH{1'b0}};
      cnt_q      <= {CW{1'b0}};
      bw_q       <= 1'b0;
      busy_out   <= 1'b0;
      done_out   <= 1'b0;
      diff_out   <= {WIDTH{1'b0}};
      borrow_out <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_out    <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          done_out <= 1'b0;
          if (start_in) begin
            state_q  <= RUN;
            acc_q    <= a_in;
            sub_q    <= b_in;
            cnt_q    <= {CW{1'b0}};
            bw_q     <= 1'b0;
            busy_out <= 1'b1;
          end else begin
            busy_out <= 1'b0;
          end
        end
        RUN: begin
          acc_q <= acc_d;
          sub_q <= sub_q >> 1'b1;
          bw_q  <= bw_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            state_q    <= DONE;
            busy_out   <= 1'b0;
            done_out   <= 1'b1;
            diff_out   <= acc_d;
            borrow_out <= bw_d;
`ifdef SERIAL_SUB_OVF_EN
            // on the last bit acc_q[0]/sub_q[0] are the operand sign bits and bit_d is the result sign
            ovf_out    <= (acc_q[0] ^ sub_q[0]) & (bit_d ^ acc_q[0]);
`endif
          end else begin
            busy_out <= 1'b1;
          end
        end
        DONE: begin
          state_q  <= IDLE;
          done_out <= 1'b0;
          busy_out <= 1'b0;
        end
        default: begin
          state_q  <= IDLE;
          busy_out <= 1'b0;
          done_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor at WIDTH 1, 8 and 16 running side by side.
// Honours SERIAL_SUB_OVF_EN to connect and check ovf_out.
module tb_serial_subtractor;

  typedef struct {
    logic [63:0] dif;
    logic        bor;
    logic        ovf;
    int          k;
  } exp_t;

  logic clk;
  int   cyc;
  int   checks;
  int   errors;
  int   fin_cnt;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc     = 0;
    checks  = 0;
    errors  = 0;
    fin_cnt = 0;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input int w, input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL w%0d %s: got %0h expected %0h (cycle %0d)", w, nm, act, exp, cyc);
    end
  endtask

  for (genvar gi = 0; gi < 3; gi++) begin : g_w
    localparam int W  = (gi == 0) ? 1 : ((gi == 1) ? 8 : 16);
    localparam int AB = (W > 4) ? 4 : W - 1;

    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] diff;
    logic         busy;
    logic         done;
    logic         borrow;
    logic [63:0]  last_d;
    logic         last_b;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
    logic         last_o;
`endif
    exp_t         q[$];
    exp_t         e;
    logic         bexp;
    int           k0;
    logic [W-1:0] a0;
    logic [W-1:0] b0;
    logic [W-1:0] a1;
    logic [W-1:0] b1;

    serial_subtractor #(.WIDTH(W)) u_dut (
      .clk_in    (clk),
      .rst_in    (rst),
      .start_in  (start),
      .a_in      (a),
      .b_in      (b),
      .busy_out  (busy),
      .done_out  (done),
      .diff_out  (diff),
`ifdef SERIAL_SUB_OVF_EN
      .ovf_out   (ovf),
`endif
      .borrow_out(borrow)
    );

    // Reference: plain integer arithmetic on unsigned and two's-complement views.
    function automatic exp_t mk(input logic [W-1:0] av, input logic [W-1:0] bv, input int k);
      exp_t   r;
      longint ua;
      longint ub;
      longint sa;
      longint sb;
      longint sd;
      ua = longint'(av);
      ub = longint'(bv);
      sa = av[W-1] ? ua - (longint'(1) << W) : ua;
      sb = bv[W-1] ? ub - (longint'(1) << W) : ub;
      sd = sa - sb;
      r.dif = 64'((ua - ub) & ((longint'(1) << W) - 1));
      r.bor = (ua < ub);
      r.ovf = (sd > ((longint'(1) << (W - 1)) - 1)) || (sd < -(longint'(1) << (W - 1)));
      r.k   = k;
      return r;
    endfunction

    task automatic wait_idle();
      int n;
      n = 0;
      while (q.size() != 0 && n < 4 * W + 8) begin
        @(negedge clk);
        n++;
      end
      if (q.size() != 0) begin
        chk(W, "done_timeout", longint'(q.size()), 0);
        q.delete();
      end
      @(negedge clk);
    endtask

    task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv);
      a     = av;
      b     = bv;
      start = 1'b1;
      q.push_back(mk(av, bv, cyc + 1));
      @(negedge clk);
      start = 1'b0;
      a     = W'($urandom);
      b     = W'($urandom);
      wait_idle();
      repeat ($urandom_range(0, 2)) @(negedge clk);
    endtask

    // Monitor: busy window, done timing, and result stability against the scoreboard.
    always @(negedge clk) begin
      bexp = (q.size() != 0) && (cyc >= q[0].k) && (cyc < q[0].k + W);
      chk(W, "busy", longint'(busy), longint'(bexp));
      if (done) begin
        chk(W, "busy_with_done", longint'(busy), 0);
        if (q.size() == 0) begin
          chk(W, "spurious_done", longint'(done), 0);
        end else begin
          e = q.pop_front();
          chk(W, "latency", longint'(cyc), longint'(e.k + W));
          last_d = e.dif;
          last_b = e.bor;
`ifdef SERIAL_SUB_OVF_EN
          last_o = e.ovf;
`endif
        end
      end else if (q.size() != 0 && cyc >= q[0].k + W) begin
        chk(W, "done_missing", longint'(done), 1);
        void'(q.pop_front());
      end
      chk(W, "diff", longint'(diff), longint'(last_d));
      chk(W, "borrow", longint'(borrow), longint'(last_b));
`ifdef SERIAL_SUB_OVF_EN
      chk(W, "ovf", longint'(ovf), longint'(last_o));
`endif
    end

    initial begin
      rst    = 1'b1;
      start  = 1'b0;
      a      = {W{1'b0}};
      b      = {W{1'b0}};
      last_d = 64'd0;
      last_b = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      last_o = 1'b0;
`endif
      repeat (3) @(negedge clk);
      chk(W, "rst_done", longint'(done), 0);
      rst = 1'b0;

      do_op(W'(8'h05), W'(8'h03));
      do_op(W'(8'h03), W'(8'h05));
      do_op(W'(8'h80), W'(8'h01));
      do_op(W'(8'h7F), W'(8'hFF));
      do_op({W{1'b0}}, {W{1'b1}});
      do_op({W{1'b1}}, {W{1'b1}});

      // start held high; operands change right after the first capture
      a0 = W'($urandom);
      b0 = W'($urandom);
      a1 = ~a0;
      b1 = W'($urandom);
      a = a0;
      b = b0;
      start = 1'b1;
      k0 = cyc + 1;
      q.push_back(mk(a0, b0, k0));
      @(negedge clk);
      a = a1;
      b = b1;
      q.push_back(mk(a1, b1, k0 + W + 2));
      while (cyc < k0 + W + 2) @(negedge clk);
      start = 1'b0;
      wait_idle();

      // reset in the middle of RUN: outputs clear at once, the aborted op never completes
      a = W'(8'hAA);
      b = W'(8'h55);
      start = 1'b1;
      k0 = cyc + 1;
      q.push_back(mk(a, b, k0));
      @(negedge clk);
      start = 1'b0;
      while (cyc < k0 + AB) @(negedge clk);
      #2;
      rst = 1'b1;
      q.delete();
      last_d = 64'd0;
      last_b = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      last_o = 1'b0;
      #1;
      chk(W, "rst_async_ovf", longint'(ovf), 0);
`else
      #1;
`endif
      chk(W, "rst_async_busy", longint'(busy), 0);
      chk(W, "rst_async_done", longint'(done), 0);
      chk(W, "rst_async_diff", longint'(diff), 0);
      chk(W, "rst_async_borrow", longint'(borrow), 0);
      @(negedge clk);
      rst = 1'b0;
      do_op(W'(8'h10), W'(8'h10));

      for (int i = 0; i < 1000; i++) begin
        do_op(W'($urandom), W'($urandom));
      end
      fin_cnt++;
    end
  end

  initial begin
    int n;
    n = 0;
    while (fin_cnt < 3 && n < 90000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (fin_cnt < 3) begin
      errors++;
      $display("FAIL global_timeout: finished %0d of 3 widths", fin_cnt);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
